// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the CPU pipeline stages.
// Provides the word type, the fetch FSM states and the word size in bytes.
package cpu_types_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus between fetch and imem.
// master = fetch (iREN, imemaddr out; imemload, ihit in), slave = memory.
interface fetch_unit_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] imemaddr;
    logic [WORD_W-1:0] imemload;
    logic              ihit;

    modport master (
        output iREN,
        output imemaddr,
        input  imemload,
        input  ihit
    );

    modport slave (
        input  iREN,
        input  imemaddr,
        output imemload,
        output ihit
    );
endinterface

// File: rtl/fetch_latch.sv
// fetch_latch: IF/ID pipeline register {instr, pc4, valid}.
// en loads instr_i/pc4_i with valid=1; clr (higher priority) drops valid only.
module fetch_latch #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              clr,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc4_i,
    output logic [WORD_W-1:0] instr_q,
    output logic [WORD_W-1:0] pc4_q,
    output logic              valid_q
);

    logic [WORD_W-1:0] instr_d;
    logic [WORD_W-1:0] pc4_d;
    logic              valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (en) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage; requests imem at pc, fills IF/ID, drives pc_next/pcWEN.
// Ports: CLK, nRST, pc in, pc_next/pcWEN out, imem bus (master), stall, flush,
// redirect_pc, halt_req in; instr_out, pc4_out, valid_out, halted out.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int              WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_next,
    output logic              pcWEN,
    fetch_unit_if.master      imem,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] pc4_out,
    output logic              valid_out,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic              squash_q, squash_d;
    logic              halt_pend_q, halt_pend_d;
    logic [WORD_W-1:0] tgt_q, tgt_d;
    logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
    logic [WORD_W-1:0] buf_pc4_q, buf_pc4_d;

    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] lat_instr;
    logic [WORD_W-1:0] lat_pc4;
    logic              lat_en;
    logic              lat_clr;
    logic              iren_c;
    logic              pcwen_c;

    assign pc4           = pc + WORD_W'(WORD_BYTES);
    assign imem.imemaddr = pc;
    // No request or PC write while reset is held: in-flight ihit is ignored.
    assign imem.iREN     = iren_c & nRST;
    assign pcWEN         = pcwen_c & nRST;
    assign halted        = (state_q == HALT);

    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        halt_pend_d = halt_pend_q;
        tgt_d       = tgt_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        iren_c      = 1'b0;
        pcwen_c     = 1'b0;
        pc_next     = pc4;
        lat_en      = 1'b0;
        lat_clr     = 1'b0;
        lat_instr   = imem.imemload;
        lat_pc4     = pc4;
        unique case (state_q)
            FETCH: begin
                iren_c = 1'b1;
                if (halt_req || halt_pend_q) begin
                    // Let the outstanding request finish, then drop it.
                    lat_clr = 1'b1;
                    if (imem.ihit) begin
                        state_d     = HALT;
                        halt_pend_d = 1'b0;
                    end else begin
                        halt_pend_d = 1'b1;
                    end
                end else if (imem.ihit && (squash_q || flush)) begin
                    pc_next  = flush ? redirect_pc : tgt_q;
                    pcwen_c  = 1'b1;
                    squash_d = 1'b0;
                    lat_clr  = 1'b1;
                end else if (imem.ihit && !stall) begin
                    lat_en  = 1'b1;
                    pcwen_c = 1'b1;
                end else if (imem.ihit) begin
                    // Decode stalled: park the word, keep the PC moving.
                    buf_instr_d = imem.imemload;
                    buf_pc4_d   = pc4;
                    pcwen_c     = 1'b1;
                    state_d     = HOLD;
                end else if (flush) begin
                    // Address must stay put until ihit; redirect later.
                    squash_d = 1'b1;
                    tgt_d    = redirect_pc;
                    lat_clr  = 1'b1;
                end
            end
            HOLD: begin
                if (halt_req) begin
                    state_d = HALT;
                    lat_clr = 1'b1;
                end else if (flush) begin
                    lat_clr = 1'b1;
                    pc_next = redirect_pc;
                    pcwen_c = 1'b1;
                    state_d = FETCH;
                end else if (!stall) begin
                    lat_en    = 1'b1;
                    lat_instr = buf_instr_q;
                    lat_pc4   = buf_pc4_q;
                    state_d   = FETCH;
                end
            end
            HALT: begin
                lat_clr = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            tgt_q       <= PC_INIT;
            buf_instr_q <= '0;
            buf_pc4_q   <= '0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            halt_pend_q <= halt_pend_d;
            tgt_q       <= tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
        end
    end

    fetch_latch #(
        .WORD_W (WORD_W)
    ) u_if_id (
        .CLK     (CLK),
        .nRST    (nRST),
        .en      (lat_en),
        .clr     (lat_clr),
        .instr_i (lat_instr),
        .pc4_i   (lat_pc4),
        .instr_q (instr_out),
        .pc4_q   (pc4_out),
        .valid_q (valid_out)
    );

endmodule
